bb_sequencer: RTL and testbench

BB_SEQUENCER -- requirements
Module: bb_sequencer

---
 rtl/bb_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_bb_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bb_sequencer.sv
// bb_sequencer: control sequencer for a statically scheduled datapath built from basic blocks.
//
// Each basic block runs for a configurable number of enabled cycles (latency table, 0 means 1),
// then the sequencer parks in WAIT_BR until the datapath returns a branch decision: exit, or a
// jump to another block (self-loops allowed). Out-of-range targets end execution with err set.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   start                            begin execution at ENTRY_BLOCK (ignored unless idle)
//   abort                            synchronous return to idle, highest priority
//   stall                            freezes block progress while executing
//   cfg_we / cfg_addr / cfg_lat      latency table write port (out-of-range addresses dropped)
//   br_valid / br_target / br_exit   branch decision, only sampled in WAIT_BR
//   enable                           datapath / PHI register enable
//   cur_block                        ID of the executing block
//   pred_onehot                      one-hot predecessor block, drives PHI input valid bits
//   phi_valid                        first enabled cycle of a block entered by a branch
//   busy / done / err                status (done is a one-cycle pulse, err sticky until start)
//   perf_cycles / perf_stalls        busy-cycle and stalled-EXEC-cycle counters
//
// Build option
//   BB_SEQUENCER_PERF_EN  defined: saturating perf counters, cleared on start.
//                         undefined: perf outputs tied to zero.

module bb_sequencer #(
    parameter int unsigned NUM_BLOCKS  = 4,
    parameter int unsigned ENTRY_BLOCK = 0,
    parameter int unsigned LAT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             stall,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [LAT_W-1:0] cfg_lat,
    input  logic             br_valid,
    input  logic [3:0]       br_target,
    input  logic             br_exit,
    output logic             enable,
    output logic [3:0]       cur_block,
    output logic [15:0]      pred_onehot,
    output logic             phi_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stalls
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWaitBr,
        StDone
    } state_e;

    localparam logic [4:0]       NumBlocksW = 5'(NUM_BLOCKS);
    localparam logic [3:0]       EntryId    = 4'(ENTRY_BLOCK);
    localparam logic [LAT_W-1:0] LatOne     = LAT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       cur_q, cur_d;
    logic [15:0]      pred_q, pred_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             branched_q, branched_d;
    logic             err_q, err_d;
    logic             tgt_ok;

    // Sized for the full 4-bit ID space; entries at or above NUM_BLOCKS are never written,
    // stay constant and are only read for legal IDs.
    logic [LAT_W-1:0] lat_tab_q [16];

    function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] l);
        return (l == '0) ? LatOne : l;
    endfunction

    // Latency table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                lat_tab_q[i] <= LatOne;
            end
        end else if (cfg_we && ({1'b0, cfg_addr} < NumBlocksW)) begin
            lat_tab_q[cfg_addr] <= cfg_lat;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cur_q      <= EntryId;
            pred_q     <= '0;
            cnt_q      <= '0;
            lat_q      <= LatOne;
            branched_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            pred_q     <= pred_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            branched_q <= branched_d;
            err_q      <= err_d;
        end
    end

    // Next state
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        pred_d     = pred_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        branched_d = branched_q;
        err_d      = err_q;
        tgt_ok     = ({1'b0, br_target} < NumBlocksW);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StExec;
                    cur_d      = EntryId;
                    pred_d     = '0;
                    cnt_d      = '0;
                    lat_d      = eff_lat(lat_tab_q[EntryId]);
                    branched_d = 1'b0;
                    err_d      = 1'b0;
                end
            end
            StExec: begin
                if (!stall) begin
                    if (cnt_q == lat_q - LatOne) begin
                        state_d = StWaitBr;
                    end else begin
                        cnt_d = cnt_q + LatOne;
                    end
                end
            end
            StWaitBr: begin
                if (br_valid) begin
                    if (br_exit) begin
                        state_d = StDone;
                    end else if (tgt_ok) begin
                        state_d    = StExec;
                        pred_d     = 16'b1 << cur_q;
                        cur_d      = br_target;
                        cnt_d      = '0;
                        lat_d      = eff_lat(lat_tab_q[br_target]);
                        branched_d = 1'b1;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides every transition but keeps block context and err for inspection.
        if (abort) begin
            state_d    = StIdle;
            cur_d      = cur_q;
            pred_d     = pred_q;
            cnt_d      = cnt_q;
            lat_d      = lat_q;
            branched_d = branched_q;
            err_d      = err_q;
        end
    end

    // Outputs
    always_comb begin
        enable      = (state_q == StExec) && !stall;
        busy        = (state_q == StExec) || (state_q == StWaitBr);
        done        = (state_q == StDone);
        err         = err_q;
        cur_block   = cur_q;
        pred_onehot = pred_q;
        // Entry block has no predecessor, so PHI inputs are only qualified after a branch.
        phi_valid   = (state_q == StExec) && !stall && (cnt_q == '0) && branched_q;
    end

`ifdef BB_SEQUENCER_PERF_EN
    logic        start_acc;
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stalls_q;

    assign start_acc = (state_q == StIdle) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (start_acc) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (busy && (perf_cycles_q != '1)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if ((state_q == StExec) && stall && (perf_stalls_q != '1)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`else
    assign perf_cycles = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_bb_sequencer.sv
// Bench for bb_sequencer. Stimulus is generated as whole programs (block latencies, stall
// bursts, branch-decision delays, targets, optional abort); the expected per-cycle outputs are
// derived from that plan and queued, and an independent monitor pops and compares each cycle.

module tb_bb_sequencer;

    localparam int unsigned NB    = 4;
    localparam int unsigned ENTRY = 0;
    localparam int unsigned LW    = 8;

    localparam int ST_I = 0;
    localparam int ST_E = 1;
    localparam int ST_W = 2;
    localparam int ST_D = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          stall = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [LW-1:0] cfg_lat = '0;
    logic          br_valid = 1'b0;
    logic [3:0]    br_target = '0;
    logic          br_exit = 1'b0;
    logic          enable;
    logic [3:0]    cur_block;
    logic [15:0]   pred_onehot;
    logic          phi_valid;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   perf_cycles;
    logic [31:0]   perf_stalls;

    always #5 clk = ~clk;

    bb_sequencer #(
        .NUM_BLOCKS (NB),
        .ENTRY_BLOCK(ENTRY),
        .LAT_W      (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_lat    (cfg_lat),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .br_exit    (br_exit),
        .enable     (enable),
        .cur_block  (cur_block),
        .pred_onehot(pred_onehot),
        .phi_valid  (phi_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .perf_cycles(perf_cycles),
        .perf_stalls(perf_stalls)
    );

    typedef struct packed {
        logic        en;
        logic        bz;
        logic        dn;
        logic        er;
        logic        phi;
        logic [3:0]  cur;
        logic [15:0] pred;
        logic [31:0] pc;
        logic [31:0] ps;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   rst_chk = 1'b0;

    // Reference model state
    int          m_tab[16];
    int          m_cur;
    logic [15:0] m_pred;
    bit          m_err;
    int unsigned m_pc;
    int unsigned m_ps;

    // Stimulus knobs
    bit          g_cfg_rnd = 1'b0;
    bit          g_fw = 1'b0;
    logic [3:0]  g_fa = '0;
    logic [7:0]  g_fl = '0;
    bit          g_stall_en = 1'b0;
    int          g_stall_fix = -1;
    bit          g_wait_en = 1'b0;
    bit          g_bad_en = 1'b0;
    bit          g_bad_force = 1'b0;
    logic [3:0]  g_tgts[$];
    int          g_jc;
    int          g_abort_at;

    function automatic string fmt(input obs_t o);
        return $sformatf("en=%b busy=%b done=%b err=%b phi=%b cur=%0d pred=%h pc=%0d ps=%0d",
                         o.en, o.bz, o.dn, o.er, o.phi, o.cur, o.pred, o.pc, o.ps);
    endfunction

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rt();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic bit rstall();
        return g_stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    endfunction

    // Monitor: one expected record per cycle, sampled on the falling edge. A reset edge that
    // arrives while clk is high is the mid-cycle asynchronous reset check.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk or negedge rst_n);
            if (clk === 1'b1) begin
                if (rst_chk) begin
                    #1;
                    a = {enable, busy, done, err, phi_valid, cur_block, pred_onehot,
                         perf_cycles, perf_stalls};
                    e = '{en: 1'b0, bz: 1'b0, dn: 1'b0, er: 1'b0, phi: 1'b0,
                          cur: 4'(ENTRY), pred: 16'h0, pc: 32'h0, ps: 32'h0};
                    vectors++;
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL async_reset got %s want %s", fmt(a), fmt(e));
                    end
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {enable, busy, done, err, phi_valid, cur_block, pred_onehot,
                     perf_cycles, perf_stalls};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle@%0t got %s want %s", $time, fmt(a), fmt(e));
                end
            end
        end
    end

    // One clock of stimulus plus the outputs the plan says the DUT shows during that clock.
    task automatic tick(input int st, input bit phi, input bit stl, input bit strt,
                        input bit abrt, input bit brv, input logic [3:0] brt, input bit brx);
        obs_t       e;
        bit         we;
        logic [3:0] ad;
        logic [7:0] lt;
        @(posedge clk);
        #1;
        we = 1'b0;
        ad = '0;
        lt = '0;
        if (g_fw) begin
            we = 1'b1;
            ad = g_fa;
            lt = g_fl;
        end else if (g_cfg_rnd && ($urandom_range(0, 4) == 0)) begin
            we = 1'b1;
            ad = rt();
            lt = 8'($urandom_range(0, 5));
        end
        start     = strt;
        abort     = abrt;
        stall     = stl;
        br_valid  = brv;
        br_target = brt;
        br_exit   = brx;
        cfg_we    = we;
        cfg_addr  = ad;
        cfg_lat   = lt;

        e.en   = (st == ST_E) && !stl;
        e.bz   = (st == ST_E) || (st == ST_W);
        e.dn   = (st == ST_D);
        e.er   = m_err;
        e.phi  = phi && !stl;
        e.cur  = 4'(m_cur);
        e.pred = m_pred;
`ifdef BB_SEQUENCER_PERF_EN
        e.pc = m_pc;
        e.ps = m_ps;
`else
        e.pc = '0;
        e.ps = '0;
`endif
        exp_q.push_back(e);

        if (e.bz) m_pc++;
        if (st == ST_E && stl) m_ps++;
        if (we && (int'(ad) < NB)) m_tab[ad] = int'(lt);
    endtask

    task automatic cyc(input int st, input bit phi, input bit stl, input bit brv,
                       input logic [3:0] brt, input bit brx, output bit ab);
        ab = (g_jc == g_abort_at);
        g_jc++;
        tick(st, phi, stl, rb(), ab, brv, brt, brx);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick(ST_I, 1'b0, rstall(), 1'b0, 1'b0, rb(), rt(), rb());
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] l);
        g_fw = 1'b1;
        g_fa = a;
        g_fl = l;
        tick(ST_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        g_fw = 1'b0;
    endtask

    task automatic model_start();
        m_err  = 1'b0;
        m_cur  = ENTRY;
        m_pred = '0;
        m_pc   = 0;
        m_ps   = 0;
    endtask

    // abort_at: -1 none, -2 random, otherwise the job-cycle index (0 = first EXEC cycle).
    task automatic run_job(input int max_br, input int abort_at);
        int         lat;
        int         newlat;
        int         nbr;
        int         w;
        int         s;
        bit         ab;
        bit         branched;
        bit         last;
        bit         bad;
        logic [3:0] tgt;
        g_jc = 0;
        if (abort_at == -2)
            g_abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 24) : -1;
        else
            g_abort_at = abort_at;
        lat = eff(m_tab[ENTRY]);
        tick(ST_I, 1'b0, rstall(), 1'b1, 1'b0, rb(), rt(), rb());
        model_start();
        branched = 1'b0;
        nbr = (g_tgts.size() > 0) ? g_tgts.size() : $urandom_range(0, max_br);
        for (int b = 0; b <= nbr; b++) begin
            for (int i = 0; i < lat; i++) begin
                if (g_stall_fix >= 0) s = (i == g_stall_fix) ? 2 : 0;
                else s = (g_stall_en && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                for (int k = 0; k < s; k++) begin
                    cyc(ST_E, 1'b0, 1'b1, rb(), rt(), rb(), ab);
                    if (ab) return;
                end
                cyc(ST_E, branched && (i == 0), 1'b0, rb(), rt(), rb(), ab);
                if (ab) return;
            end
            w = (g_wait_en && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            for (int k = 0; k < w; k++) begin
                cyc(ST_W, 1'b0, rstall(), 1'b0, rt(), rb(), ab);
                if (ab) return;
            end
            last = (b == nbr);
            bad  = last && (g_bad_force || (g_bad_en && $urandom_range(0, 2) == 0));
            if (!last) tgt = (g_tgts.size() > 0) ? g_tgts.pop_front() : 4'($urandom_range(0, NB - 1));
            else if (bad) tgt = g_bad_force ? 4'd5 : 4'($urandom_range(NB, 15));
            else tgt = rt();
            newlat = last ? 0 : eff(m_tab[tgt]);
            cyc(ST_W, 1'b0, rstall(), 1'b1, tgt, last && !bad, ab);
            if (ab) return;
            if (last) begin
                m_err = bad;
                tick(ST_D, 1'b0, rstall(), rb(), 1'b0, rb(), rt(), rb());
                return;
            end
            m_pred   = 16'b1 << m_cur;
            m_cur    = int'(tgt);
            branched = 1'b1;
            lat      = newlat;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_tab[i] = 1;
        m_cur  = ENTRY;
        m_pred = '0;
        m_err  = 1'b0;
        m_pc   = 0;
        m_ps   = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        gap(2);
        // 3-cycle block, immediate exit
        cfg_write(4'd0, 8'd3);
        run_job(0, -1);
        gap(2);
        // branch 0 -> 1, then exit
        cfg_write(4'd0, 8'd2);
        cfg_write(4'd1, 8'd1);
        g_tgts.push_back(4'd1);
        run_job(0, -1);
        gap(2);
        // two-cycle stall at counter 1 of a 4-cycle block
        cfg_write(4'd0, 8'd4);
        g_stall_fix = 1;
        run_job(0, -1);
        g_stall_fix = -1;
        gap(2);
        // illegal target sets err; next start clears it
        g_bad_force = 1'b1;
        run_job(0, -1);
        g_bad_force = 1'b0;
        gap(2);
        run_job(0, -1);
        gap(1);
        // abort in WAIT_BR together with br_valid
        cfg_write(4'd0, 8'd1);
        run_job(0, 1);
        gap(2);
        // self-loops, zero latency treated as one, ignored out-of-range cfg write
        cfg_write(4'd2, 8'd0);
        cfg_write(4'd6, 8'd9);
        g_tgts.push_back(4'd2);
        g_tgts.push_back(4'd2);
        g_tgts.push_back(4'd3);
        run_job(0, -1);
        gap(2);

        g_cfg_rnd  = 1'b1;
        g_stall_en = 1'b1;
        g_wait_en  = 1'b1;
        g_bad_en   = 1'b1;
        for (int j = 0; j < 60; j++) begin
            run_job(4, -2);
            gap($urandom_range(1, 3));
        end

        // Asynchronous reset during EXEC at counter 2
        g_cfg_rnd  = 1'b0;
        g_stall_en = 1'b0;
        g_wait_en  = 1'b0;
        g_bad_en   = 1'b0;
        gap(1);
        cfg_write(4'd0, 8'd6);
        cfg_write(4'd3, 8'd5);
        tick(ST_I, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        model_start();
        tick(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #2;
        rst_chk = 1'b1;
        rst_n   = 1'b0;
        #2;
        for (int i = 0; i < 16; i++) m_tab[i] = 1;
        m_cur  = ENTRY;
        m_pred = '0;
        m_err  = 1'b0;
        m_pc   = 0;
        m_ps   = 0;
        tick(ST_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #2;
        rst_n   = 1'b1;
        rst_chk = 1'b0;
        gap(1);
        // Table must be back to latency 1 everywhere
        g_tgts.push_back(4'd3);
        g_tgts.push_back(4'd1);
        g_tgts.push_back(4'd0);
        run_job(0, -1);
        gap(3);

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
